// File: rtl/i2c_cmd_pkg.sv
// i2c_cmd_pkg: i2c_master command encoding and arbiter state encoding.
package i2c_cmd_pkg;
  localparam logic [3:0] CMD_START = 4'b0001;
  localparam logic [3:0] CMD_WRITE = 4'b0010;
  localparam logic [3:0] CMD_READ  = 4'b0100;
  localparam logic [3:0] CMD_STOP  = 4'b1000;
  localparam int STOP_BIT = 3;
  typedef enum logic [1:0] {IDLE, GRANT, BUSY} state_t;
endpackage

// File: rtl/rr_pick.sv
// rr_pick: first set request at or above ptr, wrapping modulo N, as a one-hot winner.
module rr_pick #(
  parameter int N  = 2,
  parameter int PW = 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  win,
  output logic          valid
);
  always_comb begin
    win   = '0;
    valid = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!valid && req[(int'(ptr) + k) % N]) begin
        win[(int'(ptr) + k) % N] = 1'b1;
        valid = 1'b1;
      end
    end
  end
endmodule

// File: rtl/i2c_bus_arbiter.sv
// i2c_bus_arbiter: per-transaction round-robin sharing of one i2c_master, with an idle-owner watchdog.
module i2c_bus_arbiter
  import i2c_cmd_pkg::*;
#(
  parameter int N_REQ       = 2,
  parameter int TIMEOUT_CYC = 50000,
  parameter int TO_W        = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_REQ-1:0]     s_req,
  input  logic [4*N_REQ-1:0]   s_cmd,
  input  logic [8*N_REQ-1:0]   s_din,
  output logic [N_REQ-1:0]     s_done,
  output logic [7:0]           s_dout,
  output logic                 s_ack,
  output logic [N_REQ-1:0]     grant,
  output logic                 busy,
  output logic                 timeout_err,
  output logic                 m_req,
  output logic [3:0]           m_cmd,
  output logic [7:0]           m_din,
  input  logic                 m_done,
  input  logic [7:0]           m_dout,
  input  logic                 m_slave_ack
);
  localparam int PW = $clog2(N_REQ);

  state_t            st_q, st_d;
  logic [N_REQ-1:0]  grant_d, s_done_d, win;
  logic [PW-1:0]     own_q, own_d, rr_q, rr_d, win_idx, own_nxt;
  logic [TO_W-1:0]   wd_q, wd_d;
  logic [3:0]        m_cmd_d;
  logic [7:0]        m_din_d, s_dout_d;
  logic              m_req_d, to_d, s_ack_d, win_v;

  // The finishing owner's request is still up in its s_done cycle; masking it stops a re-issue.
  rr_pick #(.N(N_REQ), .PW(PW)) u_pick (
    .req   (s_req & ~s_done),
    .ptr   (rr_q),
    .win   (win),
    .valid (win_v)
  );

  assign busy    = |grant;
  assign own_nxt = (own_q == PW'(N_REQ - 1)) ? '0 : own_q + 1'b1;

  always_comb begin
    win_idx = '0;
    for (int i = 0; i < N_REQ; i++) if (win[i]) win_idx = PW'(i);
  end

  always_comb begin
    st_d     = st_q;
    grant_d  = grant;
    own_d    = own_q;
    rr_d     = rr_q;
    wd_d     = wd_q;
    m_req_d  = 1'b0;
    to_d     = 1'b0;
    s_done_d = '0;
    m_cmd_d  = m_cmd;
    m_din_d  = m_din;
    s_dout_d = s_dout;
    s_ack_d  = s_ack;
    case (st_q)
      IDLE: if (win_v) begin
        st_d    = BUSY;
        grant_d = win;
        own_d   = win_idx;
        m_req_d = 1'b1;
        m_cmd_d = s_cmd[4*win_idx +: 4];
        m_din_d = s_din[8*win_idx +: 8];
      end
      GRANT: if (s_req[own_q] && !(|s_done)) begin
        st_d    = BUSY;
        m_req_d = 1'b1;
        m_cmd_d = s_cmd[4*own_q +: 4];
        m_din_d = s_din[8*own_q +: 8];
      end else if (wd_q == TO_W'(TIMEOUT_CYC - 1)) begin
        st_d    = IDLE;
        grant_d = '0;
        rr_d    = own_nxt;
        to_d    = 1'b1;
      end else begin
        wd_d = wd_q + 1'b1;
      end
      BUSY: if (m_done) begin
        s_done_d = grant;
        s_dout_d = m_dout;
        s_ack_d  = m_slave_ack;
        wd_d     = '0;
        st_d     = m_cmd[STOP_BIT] ? IDLE : GRANT;
        grant_d  = m_cmd[STOP_BIT] ? '0 : grant;
        rr_d     = m_cmd[STOP_BIT] ? own_nxt : rr_q;
      end
      default: st_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q        <= IDLE;
      grant       <= '0;
      own_q       <= '0;
      rr_q        <= '0;
      wd_q        <= '0;
      m_req       <= 1'b0;
      timeout_err <= 1'b0;
      s_done      <= '0;
      m_cmd       <= '0;
      m_din       <= '0;
      s_dout      <= '0;
      s_ack       <= 1'b0;
    end else begin
      st_q        <= st_d;
      grant       <= grant_d;
      own_q       <= own_d;
      rr_q        <= rr_d;
      wd_q        <= wd_d;
      m_req       <= m_req_d;
      timeout_err <= to_d;
      s_done      <= s_done_d;
      m_cmd       <= m_cmd_d;
      m_din       <= m_din_d;
      s_dout      <= s_dout_d;
      s_ack       <= s_ack_d;
    end
  end
endmodule

// File: tb/tb_i2c_bus_arbiter.sv
// tb_i2c_bus_arbiter: scenario tasks checked against a transaction-level arbitration model.
module tb_i2c_bus_arbiter;
  localparam int N  = 2;
  localparam int TO = 20;

  typedef struct {
    int         lat;
    logic [3:0] cmd;
    logic [7:0] din;
    logic [1:0] gnt;
    logic       to;
    logic [1:0] done;
    logic [7:0] dout;
    logic       ack;
    logic       mreq;
    logic [1:0] gnt2;
    logic [7:0] xd;
    logic       xa;
  } obs_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] s_req = '0;
  logic [3:0] cmd_r [2];
  logic [7:0] din_r [2];
  logic [7:0] s_cmd;
  logic [15:0] s_din;
  logic [1:0] s_done, grant;
  logic [7:0] s_dout, m_din;
  logic       s_ack, busy, timeout_err, m_req;
  logic [3:0] m_cmd;
  logic       m_done = 1'b0;
  logic [7:0] m_dout = '0;
  logic       m_slave_ack = 1'b0;

  int n_chk = 0, n_fail = 0;
  int mreq_cnt = 0, mreq_pairs = 0;
  logic mreq_prev = 1'b0;
  int own_m = -1, ptr_m = 0;

  assign s_cmd = {cmd_r[1], cmd_r[0]};
  assign s_din = {din_r[1], din_r[0]};

  i2c_bus_arbiter #(.N_REQ(N), .TIMEOUT_CYC(TO), .TO_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .s_req(s_req), .s_cmd(s_cmd), .s_din(s_din),
    .s_done(s_done), .s_dout(s_dout), .s_ack(s_ack), .grant(grant), .busy(busy),
    .timeout_err(timeout_err), .m_req(m_req), .m_cmd(m_cmd), .m_din(m_din),
    .m_done(m_done), .m_dout(m_dout), .m_slave_ack(m_slave_ack)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (m_req) mreq_cnt <= mreq_cnt + 1;
    if (m_req && mreq_prev) mreq_pairs <= mreq_pairs + 1;
    mreq_prev <= m_req;
  end

  // Arbitration rule: first pending requester at or after the pointer, cyclically.
  function automatic int pick(input logic [1:0] p, input int ptr);
    for (int k = 0; k < N; k++) if (p[(ptr + k) % N]) return (ptr + k) % N;
    return -1;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; s_req = '0; m_done = 1'b0;
    step(); step();
    rst_n = 1'b1;
    step();
    own_m = -1; ptr_m = 0;
  endtask

  // Plays i2c_master: waits for m_req, answers after dly cycles, samples the completion cycle.
  task automatic serve(input int dly, input logic [7:0] d, input logic a, output obs_t o);
    o.lat = 0;
    while (!m_req && o.lat < 50) begin step(); o.lat++; end
    o.cmd = m_cmd; o.din = m_din; o.gnt = grant; o.to = timeout_err;
    repeat (dly) step();
    o.xd = d; o.xa = a;
    m_done = 1'b1; m_dout = d; m_slave_ack = a;
    step();
    m_done = 1'b0;
    o.done = s_done; o.dout = s_dout; o.ack = s_ack; o.mreq = m_req; o.gnt2 = grant;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step(); step();
    n_chk++; if ({grant, busy, timeout_err, m_req, m_cmd, m_din, s_done, s_dout, s_ack} !== '0) begin n_fail++; $display("FAIL reset_outputs: got %h want 0", {grant, busy, timeout_err, m_req, m_cmd, m_din, s_done, s_dout, s_ack}); end
    rst_n = 1'b1;
    step();
    n_chk++; if ({grant, busy, m_req, s_done} !== '0) begin n_fail++; $display("FAIL reset_release_idle: got %h want 0", {grant, busy, m_req, s_done}); end
  endtask

  task automatic test_single();
    obs_t o;
    do_reset();
    cmd_r[0] = 4'b0011; din_r[0] = 8'h78; s_req = 2'b01;
    serve($urandom_range(0, 4), 8'h5A, 1'b0, o);
    n_chk++; if (o.lat !== 1) begin n_fail++; $display("FAIL single_latency: got %0d want 1", o.lat); end
    n_chk++; if (o.cmd !== 4'b0011) begin n_fail++; $display("FAIL single_cmd: got %b want 0011", o.cmd); end
    n_chk++; if (o.din !== 8'h78) begin n_fail++; $display("FAIL single_din: got %h want 78", o.din); end
    n_chk++; if (o.done !== 2'b01) begin n_fail++; $display("FAIL single_done: got %b want 01", o.done); end
    n_chk++; if ({o.dout, o.ack} !== {8'h5A, 1'b0}) begin n_fail++; $display("FAIL single_dout_ack: got %h/%b want 5a/0", o.dout, o.ack); end
    n_chk++; if ({o.gnt2, busy} !== 3'b011) begin n_fail++; $display("FAIL single_grant_held: got %b/%b want 01/1", o.gnt2, busy); end
    cmd_r[0] = 4'b1000; din_r[0] = 8'($urandom);
    serve($urandom_range(0, 4), 8'($urandom), 1'($urandom), o);
    s_req = '0;
    n_chk++; if (o.lat !== 2) begin n_fail++; $display("FAIL single_stop_latency: got %0d want 2", o.lat); end
    n_chk++; if ({o.done, o.gnt2, o.dout, o.ack} !== {2'b01, 2'b00, o.xd, o.xa}) begin n_fail++; $display("FAIL single_stop_release: got %b/%b/%h/%b want 01/00/%h/%b", o.done, o.gnt2, o.dout, o.ack, o.xd, o.xa); end
  endtask

  task automatic test_lock();
    obs_t o;
    logic [3:0] seq [3];
    seq = '{4'b0011, 4'b0010, 4'b1010};
    do_reset();
    cmd_r[1] = 4'b1011; din_r[1] = 8'($urandom); s_req = 2'b11;
    for (int i = 0; i < 3; i++) begin
      cmd_r[0] = seq[i]; din_r[0] = 8'($urandom);
      serve($urandom_range(0, 3), 8'($urandom), 1'($urandom), o);
      n_chk++; if ({o.gnt, o.done, o.cmd, o.din} !== {2'b01, 2'b01, seq[i], din_r[0]}) begin n_fail++; $display("FAIL lock_owner%0d: got %b/%b/%b/%h want 01/01/%b/%h", i, o.gnt, o.done, o.cmd, o.din, seq[i], din_r[0]); end
      n_chk++; if (o.lat !== (i == 0 ? 1 : 2)) begin n_fail++; $display("FAIL lock_latency%0d: got %0d want %0d", i, o.lat, i == 0 ? 1 : 2); end
    end
    s_req[0] = 1'b0;
    serve($urandom_range(0, 3), 8'($urandom), 1'($urandom), o);
    s_req = '0;
    n_chk++; if ({o.lat, o.gnt, o.cmd, o.din, o.done, o.gnt2} !== {32'd1, 2'b10, 4'b1011, din_r[1], 2'b10, 2'b00}) begin n_fail++; $display("FAIL lock_handover: got lat %0d gnt %b cmd %b din %h done %b after %b want 1/10/1011/%h/10/00", o.lat, o.gnt, o.cmd, o.din, o.done, o.gnt2, din_r[1]); end
  endtask

  task automatic test_round_robin();
    obs_t o;
    int w;
    do_reset();
    cmd_r[0] = 4'b1011; cmd_r[1] = 4'b1011;
    din_r[0] = 8'($urandom); din_r[1] = 8'($urandom);
    s_req = 2'b11;
    for (int i = 0; i < 3; i++) begin
      w = pick(s_req, ptr_m);
      serve($urandom_range(0, 3), 8'($urandom), 1'($urandom), o);
      n_chk++; if ({o.lat, o.gnt, o.din, o.done} !== {32'd1, 2'(1 << w), din_r[w], 2'(1 << w)}) begin n_fail++; $display("FAIL rr_turn%0d: got lat %0d gnt %b din %h done %b want 1/%b/%h", i, o.lat, o.gnt, o.din, o.done, 2'(1 << w), din_r[w]); end
      ptr_m = (w + 1) % N;
      din_r[w] = 8'($urandom);
    end
    s_req = '0;
  endtask

  task automatic test_watchdog();
    obs_t o;
    int k, c0;
    do_reset();
    cmd_r[0] = 4'b0001; din_r[0] = 8'($urandom); s_req = 2'b01;
    serve($urandom_range(0, 3), 8'($urandom), 1'($urandom), o);
    s_req = 2'b10; cmd_r[1] = 4'b1011; din_r[1] = 8'($urandom);
    c0 = mreq_cnt;
    n_chk++; if ({o.done, o.gnt2} !== 4'b0101) begin n_fail++; $display("FAIL wd_start: got done %b gnt %b want 01/01", o.done, o.gnt2); end
    k = 0;
    while (!timeout_err && k < 100) begin step(); k++; end
    n_chk++; if (k !== TO) begin n_fail++; $display("FAIL wd_delay: got %0d want %0d", k, TO); end
    n_chk++; if ({grant, busy} !== 3'b000) begin n_fail++; $display("FAIL wd_revoke: got %b/%b want 00/0", grant, busy); end
    n_chk++; if (mreq_cnt !== c0) begin n_fail++; $display("FAIL wd_no_service: got %0d m_req want %0d", mreq_cnt, c0); end
    serve($urandom_range(0, 3), 8'($urandom), 1'($urandom), o);
    s_req = '0;
    n_chk++; if ({o.lat, o.gnt, o.to, o.cmd} !== {32'd1, 2'b10, 1'b0, 4'b1011}) begin n_fail++; $display("FAIL wd_next_owner: got lat %0d gnt %b to %b cmd %b want 1/10/0/1011", o.lat, o.gnt, o.to, o.cmd); end
  endtask

  task automatic test_reset_busy();
    do_reset();
    cmd_r[0] = 4'b0011; din_r[0] = 8'($urandom); s_req = 2'b01;
    step();
    n_chk++; if ({m_req, m_cmd} !== 5'b10011) begin n_fail++; $display("FAIL rb_active: got %b want 10011", {m_req, m_cmd}); end
    #2 rst_n = 1'b0;
    #1;
    n_chk++; if ({grant, busy, timeout_err, m_req, m_cmd, m_din, s_done, s_dout, s_ack} !== '0) begin n_fail++; $display("FAIL rb_async_clear: got %h want 0", {grant, busy, timeout_err, m_req, m_cmd, m_din, s_done, s_dout, s_ack}); end
    s_req = '0;
    step();
    rst_n = 1'b1;
    step();
    m_done = 1'b1; m_dout = 8'hFF; m_slave_ack = 1'b1;
    step();
    m_done = 1'b0;
    n_chk++; if ({s_done, s_dout, s_ack, grant} !== '0) begin n_fail++; $display("FAIL rb_late_done: got %h want 0", {s_done, s_dout, s_ack, grant}); end
    step();
    n_chk++; if ({s_done, m_req} !== '0) begin n_fail++; $display("FAIL rb_quiet: got %b want 000", {s_done, m_req}); end
  endtask

  task automatic test_back_to_back();
    obs_t o;
    int c0;
    logic [3:0] seq [4];
    seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    do_reset();
    c0 = mreq_cnt;
    s_req = 2'b01;
    for (int i = 0; i < 4; i++) begin
      cmd_r[0] = seq[i]; din_r[0] = 8'($urandom);
      serve($urandom_range(0, 2), 8'($urandom), 1'($urandom), o);
      n_chk++; if ({o.lat, o.cmd, o.mreq} !== {(i == 0 ? 32'd1 : 32'd2), seq[i], 1'b0}) begin n_fail++; $display("FAIL b2b_cmd%0d: got lat %0d cmd %b mreq_in_done %b want %0d/%b/0", i, o.lat, o.cmd, o.mreq, i == 0 ? 1 : 2, seq[i]); end
    end
    s_req = '0;
    step(); step();
    n_chk++; if (mreq_cnt - c0 !== 4) begin n_fail++; $display("FAIL b2b_mreq_count: got %0d want 4", mreq_cnt - c0); end
    n_chk++; if (mreq_pairs !== 0) begin n_fail++; $display("FAIL mreq_consecutive: got %0d want 0", mreq_pairs); end
  endtask

  task automatic test_random();
    obs_t o;
    logic [1:0] pend;
    logic [3:0] sent;
    int w, lat_exp, ncmd, guard;
    do_reset();
    for (int r = 0; r < 6; r++) begin
      pend = 2'($urandom_range(1, 3));
      for (int i = 0; i < N; i++) begin cmd_r[i] = 4'($urandom) | 4'b0001; din_r[i] = 8'($urandom); end
      s_req = pend; lat_exp = 1; ncmd = 0; guard = 0;
      while (pend != 0 && guard < 20) begin
        guard++;
        w = own_m >= 0 ? own_m : pick(pend, ptr_m);
        sent = cmd_r[w];
        serve($urandom_range(0, 5), 8'($urandom), 1'($urandom), o);
        n_chk++; if ({o.lat, o.gnt, o.cmd, o.din, o.done, o.dout, o.ack} !== {lat_exp, 2'(1 << w), sent, din_r[w], 2'(1 << w), o.xd, o.xa}) begin n_fail++; $display("FAIL rand_r%0d: got lat %0d gnt %b cmd %b din %h done %b dout %h ack %b want %0d/%b/%b/%h/%b/%h/%b", r, o.lat, o.gnt, o.cmd, o.din, o.done, o.dout, o.ack, lat_exp, 2'(1 << w), sent, din_r[w], 2'(1 << w), o.xd, o.xa); end
        if (sent[3]) begin
          own_m = -1; ptr_m = (w + 1) % N; pend[w] = 1'b0; s_req = pend; lat_exp = 1; ncmd = 0;
        end else begin
          own_m = w; ncmd++; lat_exp = 2;
          cmd_r[w] = (ncmd >= 2) ? 4'b1010 : 4'($urandom_range(0, 15));
          din_r[w] = 8'($urandom);
        end
      end
      step();
    end
  endtask

  initial begin
    cmd_r[0] = '0; cmd_r[1] = '0; din_r[0] = '0; din_r[1] = '0;
    test_reset();
    test_single();
    test_lock();
    test_round_robin();
    test_watchdog();
    test_reset_busy();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete within limit");
    $fatal(1);
  end
endmodule
